arcade_input_map: RTL and testbench

ARCADE_INPUT_MAP -- requirements
Module: arcade_input_map

---
 rtl/arcade_input_pkg.sv | 100 ++++++++++
 rtl/coin_pulse.sv | 50 +++++
 rtl/arcade_input_map.sv | 122 ++++++++++++
 tb/tb_arcade_input_map.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/arcade_input_pkg.sv
// Shared definitions for the arcade input mapper.
//   - Bit positions inside a player word (directions, first button).
//   - PS/2 set-2 scancodes used by the player 1 / player 2 keyboard maps.
//   - calc_w(): player word width from the button count.
//   - map_key(): decodes a scancode into {valid, player, bit index}.
package arcade_input_pkg;

  localparam int DIR_R = 0;
  localparam int DIR_L = 1;
  localparam int DIR_D = 2;
  localparam int DIR_U = 3;
  localparam int BTN0  = 4;

  // Player 1 directions match with or without the E0 prefix (arrow keys).
  localparam logic [7:0] SC_P1_UP    = 8'h75;
  localparam logic [7:0] SC_P1_DOWN  = 8'h72;
  localparam logic [7:0] SC_P1_LEFT  = 8'h6B;
  localparam logic [7:0] SC_P1_RIGHT = 8'h74;
  localparam logic [7:0] SC_P1_BTN0  = 8'h14;
  localparam logic [7:0] SC_P1_BTN1  = 8'h11;
  localparam logic [7:0] SC_P1_BTN2  = 8'h29;
  localparam logic [7:0] SC_P1_BTN3  = 8'h12;
  localparam logic [7:0] SC_P1_START = 8'h16;
  localparam logic [7:0] SC_P1_COIN  = 8'h2E;

  localparam logic [7:0] SC_P2_UP    = 8'h2D;
  localparam logic [7:0] SC_P2_DOWN  = 8'h2B;
  localparam logic [7:0] SC_P2_LEFT  = 8'h23;
  localparam logic [7:0] SC_P2_RIGHT = 8'h34;
  localparam logic [7:0] SC_P2_BTN0  = 8'h1C;
  localparam logic [7:0] SC_P2_BTN1  = 8'h1B;
  localparam logic [7:0] SC_P2_BTN2  = 8'h15;
  localparam logic [7:0] SC_P2_BTN3  = 8'h1D;
  localparam logic [7:0] SC_P2_START = 8'h1E;
  localparam logic [7:0] SC_P2_COIN  = 8'h36;

  typedef struct packed {
    logic       valid;
    logic       player;
    logic [3:0] bit_idx;
  } key_map_t;

  function automatic int calc_w(input int num_btn);
    return num_btn + 6;
  endfunction

  function automatic key_map_t map_key(input logic ext, input logic [7:0] code,
                                       input int num_btn);
    key_map_t m;
    logic     hit;
    logic     plyr;
    int       idx;
    int       btn;
    m    = '0;
    hit  = 1'b0;
    plyr = 1'b0;
    idx  = 0;
    btn  = -1;
    case (code)
      SC_P1_UP:    begin hit = 1'b1; idx = DIR_U; end
      SC_P1_DOWN:  begin hit = 1'b1; idx = DIR_D; end
      SC_P1_LEFT:  begin hit = 1'b1; idx = DIR_L; end
      SC_P1_RIGHT: begin hit = 1'b1; idx = DIR_R; end
      default: ;
    endcase
    if (!ext) begin
      case (code)
        SC_P1_BTN0:  btn = 0;
        SC_P1_BTN1:  btn = 1;
        SC_P1_BTN2:  btn = 2;
        SC_P1_BTN3:  btn = 3;
        SC_P1_START: begin hit = 1'b1; idx = num_btn + 4; end
        SC_P1_COIN:  begin hit = 1'b1; idx = num_btn + 5; end
        SC_P2_UP:    begin hit = 1'b1; plyr = 1'b1; idx = DIR_U; end
        SC_P2_DOWN:  begin hit = 1'b1; plyr = 1'b1; idx = DIR_D; end
        SC_P2_LEFT:  begin hit = 1'b1; plyr = 1'b1; idx = DIR_L; end
        SC_P2_RIGHT: begin hit = 1'b1; plyr = 1'b1; idx = DIR_R; end
        SC_P2_BTN0:  begin plyr = 1'b1; btn = 0; end
        SC_P2_BTN1:  begin plyr = 1'b1; btn = 1; end
        SC_P2_BTN2:  begin plyr = 1'b1; btn = 2; end
        SC_P2_BTN3:  begin plyr = 1'b1; btn = 3; end
        SC_P2_START: begin hit = 1'b1; plyr = 1'b1; idx = num_btn + 4; end
        SC_P2_COIN:  begin hit = 1'b1; plyr = 1'b1; idx = num_btn + 5; end
        default: ;
      endcase
    end
    // Button entries beyond the configured button count are dropped.
    if (btn >= 0 && btn < num_btn) begin
      hit = 1'b1;
      idx = BTN0 + btn;
    end
    if (hit) begin
      m.valid   = 1'b1;
      m.player  = plyr;
      m.bit_idx = 4'(idx);
    end
    return m;
  endfunction

endpackage

// File: rtl/coin_pulse.sv
// Coin pulse stretcher: converts a press of the coin input into a pulse of
// exactly COIN_CYC clk_sys cycles.
//   clk_sys  in  system clock
//   reset    in  synchronous active-high reset
//   coin_in  in  merged coin level
//   pulse    out high while the pulse is running
// The arm flag is set only by seeing the input low while no pulse runs, so a
// held coin gives one pulse, bounces during a pulse are ignored, and a coin
// held across reset release gives nothing until released and pressed again.
module coin_pulse #(
  parameter int COIN_CYC = 2400000
) (
  input  logic clk_sys,
  input  logic reset,
  input  logic coin_in,
  output logic pulse
);

  localparam int CW = $clog2(COIN_CYC + 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          arm_q, arm_d;
  logic          start;

  always_comb begin
    start = coin_in & arm_q & (cnt_q == '0);
    cnt_d = cnt_q;
    arm_d = arm_q;
    if (start) begin
      cnt_d = CW'(COIN_CYC);
      arm_d = 1'b0;
    end else begin
      if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
      if (!coin_in && cnt_q == '0) arm_d = 1'b1;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      cnt_q <= '0;
      arm_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      arm_q <= arm_d;
    end
  end

  assign pulse = (cnt_q != '0);

endmodule

// File: rtl/arcade_input_map.sv
// Arcade input mapper: merges PS/2 keyboard state with per-player joystick
// words, applies optional 90-degree rotation and SOCD cleaning, stretches the
// coin input, and registers the result per player.
//   clk_sys     in  system clock
//   reset       in  synchronous active-high reset
//   ps2_key     in  [10] toggle, [9] pressed, [8] E0, [7:0] scancode
//   joy_in      in  per-player joystick words, player p at [p*W +: W]
//   joy_share   in  OR player 0 joystick into every player
//   rotate      in  90-degree direction remap
//   kbd_clear   in  strobe releasing all keyboard keys
//   player_out  out registered per-player control words
// Word layout: [0]R [1]L [2]D [3]U [4+k]button k [4+NUM_BTN]start [5+NUM_BTN]coin
module arcade_input_map
  import arcade_input_pkg::*;
#(
  parameter int NUM_PLAYERS  = 2,
  parameter int NUM_BTN      = 4,
  parameter int COIN_CYC     = 2400000,
  parameter bit SOCD_NEUTRAL = 1'b1
) (
  input  logic                                 clk_sys,
  input  logic                                 reset,
  input  logic [10:0]                          ps2_key,
  input  logic [NUM_PLAYERS*calc_w(NUM_BTN)-1:0] joy_in,
  input  logic                                 joy_share,
  input  logic                                 rotate,
  input  logic                                 kbd_clear,
  output logic [NUM_PLAYERS*calc_w(NUM_BTN)-1:0] player_out
);

  localparam int W   = calc_w(NUM_BTN);
  localparam int TOT = NUM_PLAYERS * W;

  logic           toggle_q, toggle_d;
  logic [TOT-1:0] kbd_q, kbd_d;
  logic [TOT-1:0] player_out_q, player_out_d;
  logic [W-1:0]   word_d [NUM_PLAYERS];
  key_map_t       key_m;
  logic           key_event;
  int             kbd_idx;

  assign key_event = ps2_key[10] ^ toggle_q;
  assign key_m     = map_key(ps2_key[8], ps2_key[7:0], NUM_BTN);

  always_comb begin
    toggle_d = ps2_key[10];
    kbd_d    = kbd_q;
    kbd_idx  = int'(key_m.player) * W + int'(key_m.bit_idx);
    // Clear wins over a concurrent event, which is simply dropped.
    if (kbd_clear) begin
      kbd_d = '0;
    end else if (key_event && key_m.valid && int'(key_m.player) < NUM_PLAYERS) begin
      for (int i = 0; i < TOT; i++) begin
        if (i == kbd_idx) kbd_d[i] = ps2_key[9];
      end
    end
  end

  for (genvar p = 0; p < NUM_PLAYERS; p++) begin : g_player
    logic [W-1:0] joy_w;
    logic [W-1:0] merged_w;
    logic [W-1:0] clean_w;
    logic         pulse_w;

    assign joy_w    = joy_in[p*W +: W] | (joy_share ? joy_in[W-1:0] : '0);
    assign merged_w = kbd_q[p*W +: W] | joy_w;

    // Rotation happens before SOCD so opposing pairs are judged in the
    // rotated frame.
    always_comb begin
      clean_w = merged_w;
      if (rotate) begin
        clean_w[DIR_U] = merged_w[DIR_L];
        clean_w[DIR_D] = merged_w[DIR_R];
        clean_w[DIR_L] = merged_w[DIR_D];
        clean_w[DIR_R] = merged_w[DIR_U];
      end
      if (SOCD_NEUTRAL) begin
        if (clean_w[DIR_U] && clean_w[DIR_D]) begin
          clean_w[DIR_U] = 1'b0;
          clean_w[DIR_D] = 1'b0;
        end
        if (clean_w[DIR_L] && clean_w[DIR_R]) begin
          clean_w[DIR_L] = 1'b0;
          clean_w[DIR_R] = 1'b0;
        end
      end
    end

    coin_pulse #(.COIN_CYC(COIN_CYC)) u_coin_pulse (
      .clk_sys (clk_sys),
      .reset   (reset),
      .coin_in (merged_w[W-1]),
      .pulse   (pulse_w)
    );

    assign word_d[p] = {pulse_w, clean_w[W-2:0]};
  end

  always_comb begin
    player_out_d = '0;
    for (int p = 0; p < NUM_PLAYERS; p++) begin
      player_out_d[p*W +: W] = word_d[p];
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      // Loading the live toggle keeps a stale level from looking like an event.
      toggle_q     <= ps2_key[10];
      kbd_q        <= '0;
      player_out_q <= '0;
    end else begin
      toggle_q     <= toggle_d;
      kbd_q        <= kbd_d;
      player_out_q <= player_out_d;
    end
  end

  assign player_out = player_out_q;

endmodule

// File: tb/tb_arcade_input_map.sv
module tb_arcade_input_map;

  localparam int NP = 2;
  localparam int NB = 4;
  localparam int W  = NB + 6;
  localparam int TW = NP * W;
  localparam int CC = 10;

  logic          clk_sys = 1'b0;
  logic          reset;
  logic [10:0]   ps2_key;
  logic [TW-1:0] joy_in;
  logic          joy_share;
  logic          rotate;
  logic          kbd_clear;
  logic [TW-1:0] out0;
  logic [TW-1:0] out1;

  int tests = 0;
  int fails = 0;

  always #5 clk_sys = ~clk_sys;

  arcade_input_map #(.NUM_PLAYERS(NP), .NUM_BTN(NB), .COIN_CYC(CC), .SOCD_NEUTRAL(1'b1)) dut0 (
    .clk_sys(clk_sys), .reset(reset), .ps2_key(ps2_key), .joy_in(joy_in),
    .joy_share(joy_share), .rotate(rotate), .kbd_clear(kbd_clear), .player_out(out0)
  );

  arcade_input_map #(.NUM_PLAYERS(NP), .NUM_BTN(NB), .COIN_CYC(CC), .SOCD_NEUTRAL(1'b0)) dut1 (
    .clk_sys(clk_sys), .reset(reset), .ps2_key(ps2_key), .joy_in(joy_in),
    .joy_share(joy_share), .rotate(rotate), .kbd_clear(kbd_clear), .player_out(out1)
  );

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk_sys);
      #1;
    end
  endtask

  task automatic send_key(input logic pressed, input logic ext, input logic [7:0] code);
    ps2_key = {~ps2_key[10], pressed, ext, code};
  endtask

  task automatic test_reset;
    reset = 1'b1;
    ps2_key = {1'b1, 1'b1, 1'b0, 8'h29};
    joy_in = '0; joy_share = 1'b0; rotate = 1'b0; kbd_clear = 1'b0;
    tick(3);
    tests++;
    if (out0 !== 20'h0) begin fails++; $display("FAIL reset_out0: got %h expected %h", out0, 20'h0); end
    tests++;
    if (out1 !== 20'h0) begin fails++; $display("FAIL reset_out1: got %h expected %h", out1, 20'h0); end
    reset = 1'b0;
    tick(3);
    tests++;
    if (out0 !== 20'h0) begin fails++; $display("FAIL reset_no_event: got %h expected %h", out0, 20'h0); end
  endtask

  task automatic test_kbd_latency;
    send_key(1'b1, 1'b0, 8'h29);
    tick();
    tests++;
    if (out0 !== 20'h0) begin fails++; $display("FAIL kbd_edge1: got %h expected %h", out0, 20'h0); end
    tick();
    tests++;
    if (out0 !== 20'h00040) begin fails++; $display("FAIL kbd_btn2_press: got %h expected %h", out0, 20'h00040); end
    send_key(1'b0, 1'b0, 8'h29);
    tick();
    tests++;
    if (out0 !== 20'h00040) begin fails++; $display("FAIL kbd_rel_edge1: got %h expected %h", out0, 20'h00040); end
    tick();
    tests++;
    if (out0 !== 20'h0) begin fails++; $display("FAIL kbd_btn2_release: got %h expected %h", out0, 20'h0); end
  endtask

  task automatic test_kbd_map;
    logic [8:0]    keys [10];
    logic [TW-1:0] exps [10];
    keys = '{9'h075, 9'h175, 9'h074, 9'h016, 9'h02D, 9'h034, 9'h01D, 9'h01E, 9'h114, 9'h05A};
    exps = '{20'h00008, 20'h00008, 20'h00001, 20'h00100, 20'h02000,
             20'h00400, 20'h20000, 20'h40000, 20'h00000, 20'h00000};
    for (int i = 0; i < 10; i++) begin
      send_key(1'b1, keys[i][8], keys[i][7:0]);
      tick(2);
      tests++;
      if (out0 !== exps[i]) begin
        fails++;
        $display("FAIL kbd_map[%0d] code %h: got %h expected %h", i, keys[i], out0, exps[i]);
      end
      send_key(1'b0, keys[i][8], keys[i][7:0]);
      tick(2);
      tests++;
      if (out0 !== 20'h0) begin
        fails++;
        $display("FAIL kbd_map_rel[%0d] code %h: got %h expected %h", i, keys[i], out0, 20'h0);
      end
    end
  endtask

  task automatic test_back_to_back;
    send_key(1'b1, 1'b0, 8'h14);
    tick();
    send_key(1'b1, 1'b0, 8'h11);
    tick();
    tests++;
    if (out0 !== 20'h00010) begin fails++; $display("FAIL b2b_first: got %h expected %h", out0, 20'h00010); end
    tick();
    tests++;
    if (out0 !== 20'h00030) begin fails++; $display("FAIL b2b_both: got %h expected %h", out0, 20'h00030); end
    send_key(1'b0, 1'b0, 8'h14);
    tick();
    send_key(1'b0, 1'b0, 8'h11);
    tick(2);
    tests++;
    if (out0 !== 20'h0) begin fails++; $display("FAIL b2b_release: got %h expected %h", out0, 20'h0); end
  endtask

  task automatic test_rotate;
    joy_in = 20'h00008;
    rotate = 1'b1;
    tick();
    tests++;
    if (out0 !== 20'h00001) begin fails++; $display("FAIL rot_up_to_right: got %h expected %h", out0, 20'h00001); end
    send_key(1'b1, 1'b0, 8'h72);
    tick(2);
    tests++;
    if (out0 !== 20'h00000) begin fails++; $display("FAIL rot_kbd_down_socd: got %h expected %h", out0, 20'h0); end
    tests++;
    if (out1 !== 20'h00003) begin fails++; $display("FAIL rot_kbd_down_raw: got %h expected %h", out1, 20'h00003); end
    send_key(1'b0, 1'b0, 8'h72);
    joy_in = 20'h00001;
    tick(2);
    tests++;
    if (out0 !== 20'h00004) begin fails++; $display("FAIL rot_right_to_down: got %h expected %h", out0, 20'h00004); end
    rotate = 1'b0;
    tick();
    tests++;
    if (out0 !== 20'h00001) begin fails++; $display("FAIL rot_off: got %h expected %h", out0, 20'h00001); end
    joy_in = '0;
    tick();
  endtask

  task automatic test_share;
    joy_in = 20'h00410;
    joy_share = 1'b1;
    tick();
    tests++;
    if (out0 !== 20'h04410) begin fails++; $display("FAIL share_on: got %h expected %h", out0, 20'h04410); end
    joy_share = 1'b0;
    tick();
    tests++;
    if (out0 !== 20'h00410) begin fails++; $display("FAIL share_off: got %h expected %h", out0, 20'h00410); end
    joy_in = '0;
    tick();
  endtask

  task automatic test_socd;
    joy_in = 20'h00003;
    tick();
    tests++;
    if (out0 !== 20'h0) begin fails++; $display("FAIL socd_lr_neutral: got %h expected %h", out0, 20'h0); end
    tests++;
    if (out1 !== 20'h00003) begin fails++; $display("FAIL socd_lr_raw: got %h expected %h", out1, 20'h00003); end
    joy_in = 20'h0000D;
    tick();
    tests++;
    if (out0 !== 20'h00001) begin fails++; $display("FAIL socd_ud_neutral: got %h expected %h", out0, 20'h00001); end
    tests++;
    if (out1 !== 20'h0000D) begin fails++; $display("FAIL socd_ud_raw: got %h expected %h", out1, 20'h0000D); end
    joy_in = 20'h03000;
    tick();
    tests++;
    if (out0 !== 20'h0) begin fails++; $display("FAIL socd_p2_neutral: got %h expected %h", out0, 20'h0); end
    tests++;
    if (out1 !== 20'h03000) begin fails++; $display("FAIL socd_p2_raw: got %h expected %h", out1, 20'h03000); end
    joy_in = '0;
    tick();
  endtask

  task automatic test_coin;
    int cnt, first, last;
    tick(2);
    // Held for 50 cycles: one pulse, visible from the 2nd edge for 10 edges.
    joy_in[19] = 1'b1;
    cnt = 0; first = 0; last = 0;
    for (int i = 1; i <= 50; i++) begin
      tick();
      if (out0[19]) begin
        cnt++;
        if (first == 0) first = i;
        last = i;
      end
    end
    tests++;
    if (cnt !== CC) begin fails++; $display("FAIL coin_held_len: got %0d expected %0d", cnt, CC); end
    tests++;
    if (first !== 2) begin fails++; $display("FAIL coin_latency: got %0d expected %0d", first, 2); end
    tests++;
    if (last !== 11) begin fails++; $display("FAIL coin_last: got %0d expected %0d", last, 11); end
    joy_in[19] = 1'b0;
    tick(3);
    joy_in[19] = 1'b1;
    cnt = 0;
    for (int i = 1; i <= 30; i++) begin
      tick();
      if (out0[19]) cnt++;
    end
    tests++;
    if (cnt !== CC) begin fails++; $display("FAIL coin_repress_len: got %0d expected %0d", cnt, CC); end
    // Bounce during the pulse, then held: still only one pulse.
    joy_in[19] = 1'b0;
    tick(3);
    joy_in[19] = 1'b1;
    cnt = 0;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (out0[19]) cnt++;
      if (i == 4) joy_in[19] = 1'b0;
      if (i == 6) joy_in[19] = 1'b1;
    end
    tests++;
    if (cnt !== CC) begin fails++; $display("FAIL coin_bounce_len: got %0d expected %0d", cnt, CC); end
    joy_in = '0;
    tick(2);
  endtask

  task automatic test_kbd_clear;
    joy_in = 20'h00400;
    tick(2);
    send_key(1'b1, 1'b0, 8'h14);
    joy_in = 20'h00600;
    tick(2);
    tests++;
    if (out0 !== 20'h00610) begin fails++; $display("FAIL clr_before: got %h expected %h", out0, 20'h00610); end
    send_key(1'b1, 1'b0, 8'h16);
    kbd_clear = 1'b1;
    tick();
    kbd_clear = 1'b0;
    tick();
    tests++;
    if (out0 !== 20'h00600) begin fails++; $display("FAIL clr_after: got %h expected %h", out0, 20'h00600); end
    joy_in = '0;
    tick(12);
    tests++;
    if (out0 !== 20'h0) begin fails++; $display("FAIL clr_idle: got %h expected %h", out0, 20'h0); end
  endtask

  task automatic test_reset_mid_pulse;
    int cnt;
    tick(2);
    joy_in = 20'h80000;
    tick(4);
    tests++;
    if (out0 !== 20'h80000) begin fails++; $display("FAIL rst_pulse_running: got %h expected %h", out0, 20'h80000); end
    reset = 1'b1;
    send_key(1'b1, 1'b0, 8'h29);
    tick();
    tests++;
    if (out0 !== 20'h0) begin fails++; $display("FAIL rst_abort: got %h expected %h", out0, 20'h0); end
    tick();
    reset = 1'b0;
    cnt = 0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (out0 !== 20'h0) cnt++;
    end
    tests++;
    if (cnt !== 0) begin fails++; $display("FAIL rst_held_quiet: got %0d active cycles expected %0d", cnt, 0); end
    joy_in = '0;
    tick(2);
    joy_in = 20'h80000;
    cnt = 0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (out0[19]) cnt++;
    end
    tests++;
    if (cnt !== CC) begin fails++; $display("FAIL rst_repress_len: got %0d expected %0d", cnt, CC); end
    joy_in = '0;
  endtask

  initial begin
    test_reset();
    test_kbd_latency();
    test_kbd_map();
    test_back_to_back();
    test_rotate();
    test_share();
    test_socd();
    test_coin();
    test_kbd_clear();
    test_reset_mid_pulse();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
